// File: rtl/chip_fifo_pkg.sv
// Shared FIFO-bank definitions: default geometry, channel-index width and the
// round-robin priority function reused by other arbiters on the chip.
package chip_fifo_pkg;

  localparam int DEF_FIFO_PTR   = 6;
  localparam int DEF_FIFO_WIDTH = 32;
  localparam int MAX_CHAN       = 16;

  function automatic int chan_w(input int num_chan);
    return $clog2(num_chan);
  endfunction

  // First requester strictly after 'last', wrapping modulo num_chan.
  // Returns 'last' when nobody requests; callers gate with |req.
  function automatic int rr_next(input logic [MAX_CHAN-1:0] req, input int last,
                                 input int num_chan);
    int   grant;
    int   idx;
    logic found;
    grant = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_CHAN; i++) begin
      idx = (last + i) % num_chan;
      if (i <= num_chan && !found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/multi_chan_sync_fifo_if.sv
// Bundle of the FIFO-bank write ports, status flags and shared read port.
interface multi_chan_sync_fifo_if
  import chip_fifo_pkg::*;
#(
  parameter int NUM_CHAN   = 4,
  parameter int FIFO_PTR   = DEF_FIFO_PTR,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
);
  localparam int CHAN_W = chan_w(NUM_CHAN);

  logic [NUM_CHAN-1:0]              write_en;
  logic [NUM_CHAN*FIFO_WIDTH-1:0]   write_data;
  logic [NUM_CHAN-1:0]              fifo_full;
  logic [NUM_CHAN-1:0]              fifo_almost_full;
  logic [NUM_CHAN-1:0]              fifo_empty;
  logic [NUM_CHAN*(FIFO_PTR+1)-1:0] fifo_count;
  logic [NUM_CHAN-1:0]              overflow;
  logic                             read_valid;
  logic                             read_ready;
  logic [FIFO_WIDTH-1:0]            read_data;
  logic [CHAN_W-1:0]                read_chan;

  modport master (
    output write_en, write_data, read_ready,
    input  fifo_full, fifo_almost_full, fifo_empty, fifo_count, overflow,
           read_valid, read_data, read_chan
  );

  modport slave (
    input  write_en, write_data, read_ready,
    output fifo_full, fifo_almost_full, fifo_empty, fifo_count, overflow,
           read_valid, read_data, read_chan
  );

endinterface

// File: rtl/sync_fifo_chan.sv
// One FIFO channel: storage, pointers, occupancy, registered flags and sticky
// overflow. The head word is presented combinationally for the shared read port.
module sync_fifo_chan #(
  parameter int FIFO_PTR   = 6,
  parameter int FIFO_WIDTH = 32,
  parameter int AFULL_LVL  = (2**FIFO_PTR) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [FIFO_WIDTH-1:0] write_data,
  input  logic                  pop,
  output logic [FIFO_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [FIFO_PTR:0]     count,
  output logic                  overflow
);
  localparam int               DEPTH     = 2**FIFO_PTR;
  localparam logic [FIFO_PTR:0] DEPTH_CNT = (FIFO_PTR+1)'(DEPTH);
  localparam logic [FIFO_PTR:0] AFULL_CNT = (FIFO_PTR+1)'(AFULL_LVL);

  logic [FIFO_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_PTR-1:0]   wr_ptr;
  logic [FIFO_PTR-1:0]   rd_ptr;
  logic [FIFO_PTR:0]     count_next;
  logic                  push;

  // Gated by the registered full flag, so a same-cycle pop never rescues a write.
  assign push      = write_en && !full;
  assign head_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      full        <= (count_next == DEPTH_CNT);
      almost_full <= (count_next >= AFULL_CNT);
      empty       <= (count_next == '0);
      if (write_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/multi_chan_sync_fifo.sv
// N-channel FIFO bank merging all channels onto one registered read port
// through a round-robin arbiter; read_chan tags each word with its source.
module multi_chan_sync_fifo
  import chip_fifo_pkg::*;
#(
  parameter int NUM_CHAN   = 4,
  parameter int FIFO_PTR   = DEF_FIFO_PTR,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int AFULL_LVL  = (2**FIFO_PTR) - 2
) (
  input logic                    clk,
  input logic                    rst,
  multi_chan_sync_fifo_if.slave  bus
);
  localparam int CHAN_W = chan_w(NUM_CHAN);

  logic [NUM_CHAN-1:0]   full_v;
  logic [NUM_CHAN-1:0]   afull_v;
  logic [NUM_CHAN-1:0]   empty_v;
  logic [NUM_CHAN-1:0]   ovf_v;
  logic [FIFO_PTR:0]     count_v [NUM_CHAN];
  logic [FIFO_WIDTH-1:0] head_v  [NUM_CHAN];
  logic [NUM_CHAN-1:0]   pop;
  logic [CHAN_W-1:0]     last_grant;
  logic [CHAN_W-1:0]     grant;
  logic                  load;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    sync_fifo_chan #(
      .FIFO_PTR   (FIFO_PTR),
      .FIFO_WIDTH (FIFO_WIDTH),
      .AFULL_LVL  (AFULL_LVL)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .write_en    (bus.write_en[c]),
      .write_data  (bus.write_data[c*FIFO_WIDTH +: FIFO_WIDTH]),
      .pop         (pop[c]),
      .head_data   (head_v[c]),
      .full        (full_v[c]),
      .almost_full (afull_v[c]),
      .empty       (empty_v[c]),
      .count       (count_v[c]),
      .overflow    (ovf_v[c])
    );
  end

  assign bus.fifo_full        = full_v;
  assign bus.fifo_almost_full = afull_v;
  assign bus.fifo_empty       = empty_v;
  assign bus.overflow         = ovf_v;

  always_comb begin
    bus.fifo_count = '0;
    for (int c = 0; c < NUM_CHAN; c++)
      bus.fifo_count[c*(FIFO_PTR+1) +: FIFO_PTR+1] = count_v[c];
  end

  // Read handshake: a word transfers on an edge where read_valid && read_ready.
  // The output register reloads whenever it is empty or being drained, which
  // gives one word per cycle while read_ready stays high.
  assign load  = (!bus.read_valid || bus.read_ready) && |(~empty_v);
  assign grant = CHAN_W'(rr_next(MAX_CHAN'(~empty_v), int'(last_grant), NUM_CHAN));
  assign pop   = load ? (NUM_CHAN'(1) << grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.read_valid <= 1'b0;
      bus.read_data  <= '0;
      bus.read_chan  <= '0;
      last_grant     <= CHAN_W'(NUM_CHAN - 1);
    end else if (load) begin
      bus.read_valid <= 1'b1;
      bus.read_data  <= head_v[grant];
      bus.read_chan  <= grant;
      last_grant     <= grant;
    end else if (bus.read_ready) begin
      bus.read_valid <= 1'b0;
    end
  end

endmodule
